// File: rtl/ofmap_writer.sv
// Output-feature-map writer: requantises NPU result beats to N-bit nibbles and
// streams packed words alternately into an even and an odd memory bank.
module ofmap_writer #(
    parameter int W  = 8,
    parameter int N  = 2,
    parameter int BG = 6,
    parameter int AW = 10
) (
    input  logic                ck,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       cfg_base,
    input  logic [AW:0]         cfg_words,
    input  logic [3:0]          cfg_shift,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [(N+BG)*W-1:0] in_data,
    output logic                wr_even_en,
    output logic [AW-1:0]       wr_even_addr,
    output logic [4*W-1:0]      wr_even_data,
    output logic                wr_odd_en,
    output logic [AW-1:0]       wr_odd_addr,
    output logic [4*W-1:0]      wr_odd_data,
    output logic                busy,
    output logic                done,
    output logic                drop
);

    localparam int              LW   = N + BG;
    localparam logic [LW-1:0]   QMAX = LW'((1 << N) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state_q, state_d;

    logic [AW-1:0]  base_q;
    logic [AW:0]    words_q;
    logic [3:0]     shift_q;
    logic [AW:0]    j_q;
    logic           drop_q;

    logic           s1_valid_q;
    logic           s1_odd_q;
    logic [AW-1:0]  s1_addr_q;
    logic [4*W-1:0] s1_data_q;
    logic [4*W-1:0] packed_d;

    logic           wr_even_en_q, wr_odd_en_q;
    logic [AW-1:0]  wr_even_addr_q, wr_odd_addr_q;
    logic [4*W-1:0] wr_even_data_q, wr_odd_data_q;

    logic start_acc;
    logic accept;
    logic last_word;
    logic pipe_empty;

    // Negative lanes clamp to zero; positive lanes shift then saturate to N bits.
    function automatic logic [3:0] requant(input logic [LW-1:0] lane, input logic [3:0] sh);
        logic [LW-1:0] mag;
        logic [3:0]    q;
        mag = lane >> sh;
        q   = '0;
        if (!lane[LW-1]) q = (mag > QMAX) ? QMAX[3:0] : mag[3:0];
        return q;
    endfunction

    assign start_acc  = (state_q == IDLE) && start;
    assign accept     = in_valid && in_ready;
    assign last_word  = (j_q + {{AW{1'b0}}, 1'b1}) == words_q;
    assign pipe_empty = !s1_valid_q && !wr_even_en_q && !wr_odd_en_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        packed_d = '0;
        for (int i = 0; i < W; i++) begin
            packed_d[4*W-1-4*i -: 4] = requant(in_data[LW*W-1-LW*i -: LW], shift_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (cfg_words == '0) ? DONE : RUN;
            RUN:     if (accept && last_word) state_d = FLUSH;
            FLUSH:   if (pipe_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == RUN) && (j_q < words_q);
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            words_q <= '0;
            shift_q <= '0;
            j_q     <= '0;
            drop_q  <= 1'b0;
        end else begin
            if (start_acc) begin
                base_q  <= cfg_base;
                words_q <= cfg_words;
                shift_q <= cfg_shift;
                j_q     <= '0;
            end else if (accept) begin
                j_q <= j_q + {{AW{1'b0}}, 1'b1};
            end
            // A start that is taken wins over a lost beat in the same cycle.
            if (start_acc)                  drop_q <= 1'b0;
            else if (in_valid && !in_ready) drop_q <= 1'b1;
        end
    end

    // Stage 1: requantised word plus its bank and bank-local address.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_odd_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_odd_q  <= j_q[0];
                s1_addr_q <= base_q + j_q[AW:1];
                s1_data_q <= packed_d;
            end
        end
    end

    // Stage 2: bank write ports; address and data hold while the strobe is low.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_even_en_q   <= 1'b0;
            wr_even_addr_q <= '0;
            wr_even_data_q <= '0;
            wr_odd_en_q    <= 1'b0;
            wr_odd_addr_q  <= '0;
            wr_odd_data_q  <= '0;
        end else begin
            wr_even_en_q <= s1_valid_q && !s1_odd_q;
            wr_odd_en_q  <= s1_valid_q && s1_odd_q;
            if (s1_valid_q && !s1_odd_q) begin
                wr_even_addr_q <= s1_addr_q;
                wr_even_data_q <= s1_data_q;
            end
            if (s1_valid_q && s1_odd_q) begin
                wr_odd_addr_q <= s1_addr_q;
                wr_odd_data_q <= s1_data_q;
            end
        end
    end

    assign wr_even_en   = wr_even_en_q;
    assign wr_even_addr = wr_even_addr_q;
    assign wr_even_data = wr_even_data_q;
    assign wr_odd_en    = wr_odd_en_q;
    assign wr_odd_addr  = wr_odd_addr_q;
    assign wr_odd_data  = wr_odd_data_q;
    assign drop         = drop_q;

endmodule

// File: doc/ofmap_writer.md
OFMAP_WRITER -- requirements
Module: ofmap_writer

Interface
REQ-001 SHALL have parameter W, default 8, meaning NPU lanes per result beat.
REQ-002 SHALL have parameter N, default 2, meaning activation bit width (N<=4).
REQ-003 SHALL have parameter BG, default 6, meaning accumulator guard bits; lane width is N+BG.
REQ-004 SHALL have parameter AW, default 10, meaning bank word-address width.
REQ-005 SHALL have port ck, input, 1, meaning clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle pulse that starts one ofmap write job.
REQ-008 SHALL have port cfg_base, input, AW, meaning the base word address in each bank.
REQ-009 SHALL have port cfg_words, input, AW+1, meaning total packed words in the job.
REQ-010 SHALL have port cfg_shift, input, 4, meaning the requantisation right-shift amount.
REQ-011 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, (N+BG)*W), meaning the result beat; lane 0 sits in the MSBs.
REQ-012 SHALL have ports wr_even_en (output, 1), wr_even_addr (output, AW) and wr_even_data (output, 4*W), meaning the even-bank write port.
REQ-013 SHALL have ports wr_odd_en (output, 1), wr_odd_addr (output, AW) and wr_odd_data (output, 4*W), meaning the odd-bank write port.
REQ-014 SHALL have ports busy (output, 1), done (output, 1) and drop (output, 1), meaning job active, one-cycle completion pulse and sticky lost-beat flag.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN, FLUSH and DONE.
REQ-016 SHALL, in IDLE on start, latch the three cfg_* inputs, clear the word counter j and drop, and go to RUN.
REQ-017 SHALL, in IDLE on start with cfg_words=0, go to DONE instead; no write issued.
REQ-018 SHALL assert in_ready only in RUN with j < cfg_words, and accept a beat when in_valid && in_ready.
REQ-019 SHALL requantise each lane per accepted beat as:
- lane treated as signed N+BG bits;
- negative -> 0;
- else arithmetic right shift by cfg_shift;
- saturate to 2^N-1;
- result q placed in a nibble as {(4-N) zeros, q}.
REQ-020 SHALL pack lane i into wr_*_data[4*W-1-4*i -: 4].
REQ-021 SHALL route packed word j by bank:
- even j -> even bank, address cfg_base + j/2;
- odd j -> odd bank, address cfg_base + (j-1)/2;
- address arithmetic modulo 2^AW (wrap, no error).
REQ-022 SHALL keep a two-stage pipeline: stage 1 registers the requantised nibbles, stage 2 registers the write port.
REQ-023 SHALL therefore raise wr_*_en exactly 2 cycles after beat acceptance, for one cycle per beat.
REQ-024 SHALL never assert wr_even_en and wr_odd_en in the same cycle.
REQ-025 SHALL move RUN -> FLUSH on acceptance of word cfg_words-1.
REQ-026 SHALL leave FLUSH when the pipeline is empty: FLUSH -> DONE, then DONE -> IDLE after one cycle.
REQ-027 SHALL assert done for exactly one cycle, in DONE.
REQ-028 SHALL assert busy in RUN, FLUSH and DONE.
REQ-029 SHALL ignore start outside IDLE.
REQ-030 SHALL set drop when in_valid && !in_ready, except in the cycle in which start is accepted (that clear has priority).
REQ-031 SHALL hold drop until the next accepted start or rst.
REQ-032 SHALL hold wr_*_addr and wr_*_data at their last values while wr_*_en=0.

Reset
REQ-033 SHALL, on rst asserted, go to IDLE, clear the pipeline valids, j and the latched cfg, and drive every output to 0.
REQ-034 SHALL, on rst asserted mid-job, abort the job: no further write strobes and no done pulse.

Verification
REQ-035 SHALL pass scenario "single beat": cfg_base=0x010, cfg_words=1, cfg_shift=2, lanes [13,-16,4,8,0,3,127,7] -> 2 cycles after acceptance wr_even_en=1, addr 0x010, data 0x30120031; done 2 cycles later; wr_odd_en never high.
REQ-036 SHALL pass scenario "alternation": cfg_base=0, cfg_words=4, one beat per cycle -> writes even@0, odd@0, even@1, odd@1 on consecutive cycles; done 2 cycles after the last write.
REQ-037 SHALL pass scenario "wrap": cfg_base=0x3FF, cfg_words=3 -> even@0x3FF, odd@0x3FF, even@0x000.
REQ-038 SHALL pass scenario "back-pressure/drop": in_valid held high for 5 cycles with cfg_words=3 -> exactly 3 writes, in_ready=0 after the third acceptance, drop=1; next start clears drop.
REQ-039 SHALL pass scenario "zero job / start in RUN": cfg_words=0 -> done 1 cycle after start, no writes; a start pulse during RUN of a 4-word job changes nothing.
REQ-040 SHALL pass scenario "reset mid-job": rst asserted after 2 of 4 beats -> all outputs 0 immediately, no done; a new job after release completes normally.
